// File: rtl/aes_cbc_pkg.sv
// rtl/aes_cbc_pkg.sv - shared widths, state encoding and chaining helper for the AES-128 CBC sequencer
package aes_cbc_pkg;

    localparam int AES_BLK_W   = 128;
    localparam int AES_KEY_W   = 128;
    localparam int AES_LAT_DEF = 10;
    localparam int NBLK_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        RUN  = 2'd2,
        EMIT = 2'd3
    } cbc_state_e;

    // CBC input block: plaintext mixed with the previous ciphertext (the IV for block 0)
    function automatic logic [AES_BLK_W-1:0] cbc_mix(
        input logic [AES_BLK_W-1:0] pt,
        input logic [AES_BLK_W-1:0] chain
    );
        return pt ^ chain;
    endfunction

endpackage

// File: rtl/aes_cbc_ctrl_if.sv
// rtl/aes_cbc_ctrl_if.sv - config, plaintext and ciphertext handshakes of the CBC sequencer
interface aes_cbc_ctrl_if #(
    parameter int NBLK_W = 16
) ();
    import aes_cbc_pkg::*;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [AES_KEY_W-1:0] cfg_key;
    logic [AES_BLK_W-1:0] cfg_iv;
    logic [NBLK_W-1:0]    cfg_nblk;

    logic                 pt_valid;
    logic                 pt_ready;
    logic [AES_BLK_W-1:0] pt_data;

    logic                 ct_valid;
    logic                 ct_ready;
    logic [AES_BLK_W-1:0] ct_data;
    logic                 ct_last;

    modport master (
        output cfg_valid, cfg_key, cfg_iv, cfg_nblk,
        output pt_valid, pt_data,
        output ct_ready,
        input  cfg_ready, pt_ready,
        input  ct_valid, ct_data, ct_last
    );

    modport slave (
        input  cfg_valid, cfg_key, cfg_iv, cfg_nblk,
        input  pt_valid, pt_data,
        input  ct_ready,
        output cfg_ready, pt_ready,
        output ct_valid, ct_data, ct_last
    );

endinterface

// File: rtl/aes_lat_timer.sv
// rtl/aes_lat_timer.sv - fixed-latency timer that flags the cycle the core result is valid
module aes_lat_timer
    import aes_cbc_pkg::*;
#(
    parameter int AES_LAT = AES_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    output logic expire
);

    localparam int               CNT_W = $clog2(AES_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(AES_LAT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    // The cycle after load is counted as 1, so expire lands AES_LAT cycles after the load cycle
    assign expire = run_q && (cnt_q == LAT_C);

    // Next count: clear wins, then load, then stop on expiry, else advance while running
    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (clear) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (load) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(1);
        end else if (expire) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/aes_cbc_ctrl.sv
// rtl/aes_cbc_ctrl.sv - multi-block AES-128 CBC sequencer for a shared core; define AES_CBC_CTRL_ABORT_EN for the abort input
module aes_cbc_ctrl
    import aes_cbc_pkg::*;
#(
    parameter int AES_LAT = AES_LAT_DEF,
    parameter int NBLK_W  = NBLK_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef AES_CBC_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    aes_cbc_ctrl_if.slave        bus,
    output logic [AES_BLK_W-1:0] core_state,
    output logic [AES_KEY_W-1:0] core_key,
    output logic                 core_start,
    input  logic [AES_BLK_W-1:0] core_out,
    output logic                 busy,
    output logic                 done
);

    cbc_state_e           state_q, state_d;
    logic [AES_KEY_W-1:0] core_key_q, core_key_d;
    logic [AES_BLK_W-1:0] chain_q, chain_d;
    logic [AES_BLK_W-1:0] core_state_q, core_state_d;
    logic [AES_BLK_W-1:0] ct_data_q, ct_data_d;
    logic [NBLK_W-1:0]    remaining_q, remaining_d;
    logic                 core_start_q, core_start_d;
    logic                 ct_valid_q, ct_valid_d;
    logic                 ct_last_q, ct_last_d;
    logic                 done_q, done_d;

    logic                 lat_load;
    logic                 lat_expire;
    logic                 abort_hit;

`ifdef AES_CBC_CTRL_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    aes_lat_timer #(
        .AES_LAT (AES_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lat_load),
        .clear  (abort_hit),
        .expire (lat_expire)
    );

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.pt_ready  = (state_q == FEED);
    assign bus.ct_valid  = ct_valid_q;
    assign bus.ct_data   = ct_data_q;
    assign bus.ct_last   = ct_last_q;
    assign core_state    = core_state_q;
    assign core_key      = core_key_q;
    assign core_start    = core_start_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

    // Sequencer: one block in flight, next plaintext only accepted once the previous ciphertext has left
    always_comb begin
        state_d      = state_q;
        core_key_d   = core_key_q;
        chain_d      = chain_q;
        core_state_d = core_state_q;
        ct_data_d    = ct_data_q;
        remaining_d  = remaining_q;
        core_start_d = 1'b0;
        ct_valid_d   = ct_valid_q;
        ct_last_d    = ct_last_q;
        done_d       = 1'b0;
        lat_load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    core_key_d  = bus.cfg_key;
                    chain_d     = bus.cfg_iv;
                    remaining_d = bus.cfg_nblk;
                    if (bus.cfg_nblk != '0) begin
                        state_d = FEED;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (bus.pt_valid) begin
                    core_state_d = cbc_mix(bus.pt_data, chain_q);
                    core_start_d = 1'b1;
                    lat_load     = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (lat_expire) begin
                    ct_data_d  = core_out;
                    chain_d    = core_out;
                    ct_last_d  = (remaining_q == NBLK_W'(1));
                    ct_valid_d = 1'b1;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (bus.ct_ready) begin
                    remaining_d = remaining_q - NBLK_W'(1);
                    ct_valid_d  = 1'b0;
                    ct_last_d   = 1'b0;
                    if (remaining_q == NBLK_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides any handshake in the same cycle and drops the in-flight block
        if (abort_hit) begin
            state_d      = IDLE;
            ct_valid_d   = 1'b0;
            ct_last_d    = 1'b0;
            core_start_d = 1'b0;
            lat_load     = 1'b0;
            done_d       = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            core_key_q   <= '0;
            chain_q      <= '0;
            core_state_q <= '0;
            ct_data_q    <= '0;
            remaining_q  <= '0;
            core_start_q <= 1'b0;
            ct_valid_q   <= 1'b0;
            ct_last_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_key_q   <= core_key_d;
            chain_q      <= chain_d;
            core_state_q <= core_state_d;
            ct_data_q    <= ct_data_d;
            remaining_q  <= remaining_d;
            core_start_q <= core_start_d;
            ct_valid_q   <= ct_valid_d;
            ct_last_q    <= ct_last_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// tb/tb_aes_cbc_ctrl.sv - directed-vector bench for aes_cbc_ctrl with a lookup-table core stub
module tb_aes_cbc_ctrl;

    localparam int           MAIN_LAT = 10;
    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] IN1  = 128'h6bc0bce12a459991e134741a7f9e1925;
    localparam logic [127:0] CT1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] IN2  = 128'hd86421fb9f1a1eda505ee1375746972c;
    localparam logic [127:0] CT2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] JUNK = {4{32'hdeadbeef}};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   lat_fin_cnt = 0;

    always #5 clk = ~clk;

    // Known AES-128 pairs for the test key; anything else yields a distinct non-AES value
    function automatic logic [127:0] aes_ref(input logic [127:0] s, input logic [127:0] k);
        if (k != KEY) return JUNK;
        if (s == IN1) return CT1;
        if (s == IN2) return CT2;
        return {s[63:0], s[127:64]} ^ {4{32'h5a5a5a5a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    aes_cbc_ctrl_if #(.NBLK_W(16)) bus ();
    logic [127:0] core_state, core_key, core_out;
    logic         core_start, busy, done;
`ifdef AES_CBC_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif

    aes_cbc_ctrl #(
        .AES_LAT (MAIN_LAT),
        .NBLK_W  (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef AES_CBC_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .bus        (bus),
        .core_state (core_state),
        .core_key   (core_key),
        .core_start (core_start),
        .core_out   (core_out),
        .busy       (busy),
        .done       (done)
    );

    int   stub_age;
    logic stub_armed;

    always @(posedge clk) begin
        if (!rst_n) begin
            stub_armed <= 1'b0;
            stub_age   <= 0;
        end else if (core_start) begin
            stub_armed <= 1'b1;
            stub_age   <= 1;
        end else if (stub_armed) begin
            stub_age   <= stub_age + 1;
        end
    end

    assign core_out = ((core_start && MAIN_LAT == 1) ||
                       (!core_start && stub_armed && stub_age == MAIN_LAT - 1))
                      ? aes_ref(core_state, core_key) : JUNK;

    task automatic check_reset_outputs(input string p);
        check({p, "_cfg_ready"},  128'(bus.cfg_ready), 128'd1);
        check({p, "_pt_ready"},   128'(bus.pt_ready),  128'd0);
        check({p, "_ct_valid"},   128'(bus.ct_valid),  128'd0);
        check({p, "_ct_last"},    128'(bus.ct_last),   128'd0);
        check({p, "_ct_data"},    bus.ct_data,         128'd0);
        check({p, "_core_state"}, core_state,          128'd0);
        check({p, "_core_key"},   core_key,            128'd0);
        check({p, "_core_start"}, 128'(core_start),    128'd0);
        check({p, "_busy"},       128'(busy),          128'd0);
        check({p, "_done"},       128'(done),          128'd0);
    endtask

    task automatic do_cfg(input logic [127:0] key, input logic [127:0] iv, input logic [15:0] nblk);
        check("cfg_ready_before_cfg", 128'(bus.cfg_ready), 128'd1);
        bus.cfg_valid = 1'b1;
        bus.cfg_key   = key;
        bus.cfg_iv    = iv;
        bus.cfg_nblk  = nblk;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_pt(input logic [127:0] d);
        int n = 0;
        bus.pt_valid = 1'b1;
        bus.pt_data  = d;
        while (!bus.pt_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("pt_ready_timeout", 128'd0, 128'd1);
        tick();
        bus.pt_valid = 1'b0;
    endtask

    task automatic run_block(input string p, input logic [127:0] pt, input logic [127:0] exp_state,
                             input logic [127:0] exp_ct, input logic exp_last);
        int lat;
        send_pt(pt);
        check({p, "_core_start"},  128'(core_start), 128'd1);
        check({p, "_core_state"},  core_state,       exp_state);
        check({p, "_core_key"},    core_key,         KEY);
        check({p, "_pt_ready_run"}, 128'(bus.pt_ready), 128'd0);
        tick();
        check({p, "_core_start_pulse"}, 128'(core_start), 128'd0);
        lat = 1;
        while (!bus.ct_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({p, "_latency"}, 128'(lat),         128'(MAIN_LAT));
        check({p, "_ct_data"}, bus.ct_data,        exp_ct);
        check({p, "_ct_last"}, 128'(bus.ct_last),  128'(exp_last));
    endtask

    task automatic take_ct();
        bus.ct_ready = 1'b1;
        tick();
        bus.ct_ready = 1'b0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int L = (g == 0) ? 1 : 14;

        aes_cbc_ctrl_if #(.NBLK_W(16)) lbus ();
        logic [127:0] l_core_state, l_core_key, l_core_out;
        logic         l_core_start, l_busy, l_done;
        int           l_age;
        logic         l_armed;

        aes_cbc_ctrl #(
            .AES_LAT (L),
            .NBLK_W  (16)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
`ifdef AES_CBC_CTRL_ABORT_EN
            .abort      (1'b0),
`endif
            .bus        (lbus),
            .core_state (l_core_state),
            .core_key   (l_core_key),
            .core_start (l_core_start),
            .core_out   (l_core_out),
            .busy       (l_busy),
            .done       (l_done)
        );

        always @(posedge clk) begin
            if (!rst_n) begin
                l_armed <= 1'b0;
                l_age   <= 0;
            end else if (l_core_start) begin
                l_armed <= 1'b1;
                l_age   <= 1;
            end else if (l_armed) begin
                l_age   <= l_age + 1;
            end
        end

        assign l_core_out = ((l_core_start && L == 1) ||
                             (!l_core_start && l_armed && l_age == L - 1))
                            ? aes_ref(l_core_state, l_core_key) : JUNK;

        initial begin
            int n;
            lbus.cfg_valid = 1'b0;
            lbus.cfg_key   = '0;
            lbus.cfg_iv    = '0;
            lbus.cfg_nblk  = '0;
            lbus.pt_valid  = 1'b0;
            lbus.pt_data   = '0;
            lbus.ct_ready  = 1'b0;
            wait (rst_n === 1'b1);
            tick();
            lbus.cfg_valid = 1'b1;
            lbus.cfg_key   = KEY;
            lbus.cfg_iv    = IV;
            lbus.cfg_nblk  = 16'd1;
            tick();
            lbus.cfg_valid = 1'b0;
            lbus.pt_valid  = 1'b1;
            lbus.pt_data   = PT1;
            check($sformatf("lat%0d_pt_ready", L), 128'(lbus.pt_ready), 128'd1);
            tick();
            lbus.pt_valid = 1'b0;
            n = 0;
            while (!lbus.ct_valid && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("lat%0d_cycles", L),   128'(n),            128'(L));
            check($sformatf("lat%0d_ct_data", L),  lbus.ct_data,        CT1);
            check($sformatf("lat%0d_ct_last", L),  128'(lbus.ct_last),  128'd1);
            check($sformatf("lat%0d_core_key", L), l_core_key,          KEY);
            lbus.ct_ready = 1'b1;
            tick();
            lbus.ct_ready = 1'b0;
            check($sformatf("lat%0d_done", L), 128'(l_done), 128'd1);
            check($sformatf("lat%0d_busy", L), 128'(l_busy), 128'd0);
            lat_fin_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_key   = '0;
        bus.cfg_iv    = '0;
        bus.cfg_nblk  = '0;
        bus.pt_valid  = 1'b0;
        bus.pt_data   = '0;
        bus.ct_ready  = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        do_cfg(KEY, IV, 16'd1);
        check("t1_busy",      128'(busy),          128'd1);
        check("t1_cfg_ready", 128'(bus.cfg_ready), 128'd0);
        check("t1_pt_ready",  128'(bus.pt_ready),  128'd1);
        check("t1_done_cfg",  128'(done),          128'd0);
        run_block("t1", PT1, IN1, CT1, 1'b1);
        take_ct();
        check("t1_done",      128'(done),          128'd1);
        check("t1_ct_valid",  128'(bus.ct_valid),  128'd0);
        check("t1_ct_last",   128'(bus.ct_last),   128'd0);
        check("t1_busy_end",  128'(busy),          128'd0);
        tick();
        check("t1_done_pulse", 128'(done),         128'd0);

        do_cfg(KEY, IV, 16'd2);
        run_block("t2b1", PT1, IN1, CT1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_ct_valid",   128'(bus.ct_valid), 128'd1);
            check("bp_ct_data",    bus.ct_data,        CT1);
            check("bp_pt_ready",   128'(bus.pt_ready), 128'd0);
            check("bp_core_start", 128'(core_start),   128'd0);
        end
        take_ct();
        check("t2_done_mid",  128'(done),         128'd0);
        check("t2_pt_ready",  128'(bus.pt_ready), 128'd1);
        run_block("t2b2", PT2, IN2, CT2, 1'b1);
        take_ct();
        check("t2_done",      128'(done),         128'd1);
        tick();

        bus.ct_ready = 1'b1;
        do_cfg(KEY, IV, 16'd0);
        check("t3_done",       128'(done),          128'd1);
        check("t3_cfg_ready",  128'(bus.cfg_ready), 128'd1);
        check("t3_busy",       128'(busy),          128'd0);
        check("t3_core_start", 128'(core_start),    128'd0);
        tick();
        check("t3_done_pulse", 128'(done),          128'd0);
        check("t3_core_start2", 128'(core_start),   128'd0);
        check("t3_ct_valid",   128'(bus.ct_valid),  128'd0);
        bus.ct_ready = 1'b0;

        for (int i = 0; i < 200 && lat_fin_cnt < 2; i++) tick();
        check("lat_instances_finished", 128'(lat_fin_cnt), 128'd2);

        do_cfg(KEY, IV, 16'd3);
        run_block("t4b1", PT1, IN1, CT1, 1'b0);
        take_ct();
        send_pt(PT2);
        repeat (3) tick();
        check("t4_busy_run", 128'(busy), 128'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("t4_rst");
        rst_n = 1'b1;
        tick();
        check("t4_no_done", 128'(done), 128'd0);

        do_cfg(KEY, IV, 16'd1);
        run_block("t5", PT1, IN1, CT1, 1'b1);
        take_ct();
        check("t5_done", 128'(done), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/aes_cbc_ctrl.md
Name: aes_cbc_ctrl

Overview:
Sequencer that runs multi-block AES-128 CBC encryption on a single shared aes1281 core. Accepts a key, IV and block count on a config handshake, then streams plaintext blocks in and ciphertext blocks out over valid/ready. Chains each plaintext with the previous ciphertext (the IV for block 0) and times the core with a fixed-latency counter. Replaces ad-hoc serial-load and chaining glue in front of the core.

Parameters:
AES_LAT, 10, cycles from core_start to valid core_out; legal range 1..255.
NBLK_W, 16, width of block-count field.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
cfg_valid  in  1  config offer
cfg_ready  out  1  high only in IDLE
cfg_key  in  128  AES-128 key
cfg_iv  in  128  initialisation vector
cfg_nblk  in  NBLK_W  number of 128-bit blocks
pt_valid  in  1  plaintext offer
pt_ready  out  1  high only in FEED
pt_data  in  128  plaintext block
ct_valid  out  1  ciphertext available
ct_ready  in  1  ciphertext sink ready
ct_data  out  128  ciphertext block
ct_last  out  1  high with final block of message
core_state  out  128  registered core input (pt ^ chain)
core_key  out  128  registered key to core
core_start  out  1  one-cycle pulse, core input valid
core_out  in  128  core result, valid AES_LAT cycles after core_start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at message end

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all outputs 0 except cfg_ready=1; chain, key, block counter, latency counter cleared. Reset mid-message discards all in-flight data; no done pulse.
- IDLE: cfg_valid&&cfg_ready captures key->core_key, iv->chain, nblk->remaining. nblk!=0 -> FEED. nblk==0 -> stay IDLE, done pulses next cycle, no blocks.
- FEED: pt_ready=1. On pt_valid&&pt_ready at cycle t: core_state<=pt_data^chain; core_start=1 in cycle t+1 only; lat counter loaded -> RUN.
- RUN: counter counts core_start cycle as 1; in cycle t+AES_LAT (core_out valid) capture core_out into ct_data and chain; ct_last<=(remaining==1) -> EMIT. ct_valid rises in cycle t+AES_LAT+1.
- EMIT: ct_valid, ct_data, ct_last held stable until ct_ready. On handshake: remaining-=1; if remaining was 1 -> IDLE with done pulse in next cycle, ct_last and ct_valid cleared; else -> FEED.
- Only one block in flight (CBC dependency); pt_ready low in RUN/EMIT regardless of pt_valid.
- ct_ready high while ct_valid low has no effect. pt_valid may drop without handshake; no state change.
- cfg_valid outside IDLE ignored; core_key stable for whole message.
- Best-case throughput: one block per AES_LAT+2 cycles.
- remaining counter never wraps: decremented only in EMIT, where remaining>=1.

Optional Feature:
AES_CBC_CTRL_ABORT_EN: adds input abort (1 bit). When defined, abort high at any clk edge with busy=1 forces IDLE next cycle, clears ct_valid/ct_last/core_start, drops in-flight block, pulses done (same cycle as IDLE entry); abort has priority over simultaneous handshakes; abort in IDLE ignored. When undefined, port absent, message always runs to completion or reset.

Decomposition:
- Package aes_cbc_pkg: state enum (IDLE, FEED, RUN, EMIT), AES_BLK_W=128, AES_KEY_W=128, default AES_LAT.
- Sub-module aes_lat_timer (load/count/expire pulse, width from AES_LAT) is natural; everything else in one FSM module.

Test Plan:
- Single block, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, pt 6bc1bee22e409f96e93d7e117393172a -> ct 7649abac8119b246cee98e9b12e9197d, ct_last=1, done one cycle after ct handshake.
- Two blocks, same key/IV, pt2 ae2d8a571e03ac9c9eb76fac45af8e51 -> ct1 as above, ct2 5086cb9b507219ee95db113a917678b2; core_state for block 2 = pt2^ct1.
- Backpressure: ct_ready low 20 cycles in EMIT -> ct_data/ct_valid stable, pt_ready=0, core_start=0 throughout.
- cfg_nblk=0 -> no core_start, done pulses one cycle after config handshake, cfg_ready stays 1.
- rst_n low during RUN of block 2 of 3 -> next cycle all outputs at reset values, no done; fresh 1-block message then gives correct ct.
- Latency: AES_LAT=1 and AES_LAT=14 -> ct_valid rises exactly AES_LAT+1 cycles after pt handshake cycle.
